// File: rtl/pixel_stream_ctrl.sv
// pixel_stream_ctrl
// Streams one frame of N_PIXELS pixels from a 1-cycle-latency image memory to a
// valid/ready consumer. A 2-entry FIFO absorbs read data while the consumer stalls.
// Returned data bypasses the FIFO when it is empty, so the first pixel is valid the
// cycle after its read.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   start               - frame request, honoured only in IDLE
//   abort               - (PIXEL_STREAM_ABORT_EN only) drop the current frame
//   mem_rd_en, mem_addr - memory read strobe and pixel address
//   mem_rd_data         - memory data, valid one cycle after mem_rd_en
//   d_out, d_valid      - pixel to downstream and its valid flag
//   d_ready             - downstream accept; transfer = d_valid & d_ready
//   d_last              - marks pixel N_PIXELS-1
//   busy, done          - not-IDLE flag, one-cycle end-of-frame pulse
//
// Optional build macro: PIXEL_STREAM_ABORT_EN adds the abort input.
module pixel_stream_ctrl #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned N_PIXELS      = 784,
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned STARTUP_DELAY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
`ifdef PIXEL_STREAM_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rd_data,
  output logic signed [DATA_W-1:0] d_out,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic                     d_last,
  output logic                     busy,
  output logic                     done
);

  // One extra bit so the address counter can reach N_PIXELS (end of frame).
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] NUM_PIX  = CNT_W'(N_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIXELS - 1);
  localparam logic [3:0]       DLY_INIT = 4'(STARTUP_DELAY);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        r_state;
  logic [3:0]        r_dly;
  logic [CNT_W-1:0]  r_addr;
  logic [CNT_W-1:0]  r_out_idx;
  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_cnt;

  logic [1:0]        w_state_nxt;
  logic              w_in_stream;
  logic              w_abort;
  logic [1:0]        w_occ;
  logic              w_rd;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_final;
  logic              w_push;
  logic              w_fifo_pop;
  logic              w_flush;

`ifdef PIXEL_STREAM_ABORT_EN
  assign w_abort = abort & ((r_state == ST_DELAY) | (r_state == ST_STREAM));
`else
  assign w_abort = 1'b0;
`endif

  assign w_in_stream = (r_state == ST_STREAM);
  // Stored pixels plus the one arriving from memory this cycle.
  assign w_occ       = r_cnt + {1'b0, r_inflight};
  assign w_rd        = w_in_stream & ~w_abort & (w_occ < 2'd2) & (r_addr < NUM_PIX);
  assign w_head      = (r_cnt != 2'd0) ? r_fifo[r_rptr] : mem_rd_data;

  assign d_valid     = w_in_stream & (w_occ != 2'd0);
  assign d_out       = d_valid ? w_head : '0;
  assign d_last      = d_valid & (r_out_idx == LAST_IDX);
  assign w_pop       = d_valid & d_ready;
  assign w_final     = w_pop & d_last;

  // Arriving data skips the FIFO only when the FIFO is empty and it leaves at once.
  assign w_fifo_pop  = w_pop & (r_cnt != 2'd0);
  assign w_push      = r_inflight & ~(w_pop & (r_cnt == 2'd0));
  assign w_flush     = ~w_in_stream | w_abort | w_final;

  assign mem_rd_en   = w_rd;
  assign mem_addr    = r_addr[ADDR_W-1:0];
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (STARTUP_DELAY == 0) ? ST_STREAM : ST_DELAY;
      end
      ST_DELAY: begin
        if (w_abort)              w_state_nxt = ST_IDLE;
        else if (r_dly <= 4'd1)   w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_abort)              w_state_nxt = ST_IDLE;
        else if (w_final)         w_state_nxt = ST_DONE;
      end
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dly      <= '0;
      r_addr     <= '0;
      r_out_idx  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd;
      if (r_state == ST_IDLE) begin
        r_dly     <= DLY_INIT;
        r_addr    <= '0;
        r_out_idx <= '0;
      end else begin
        if (r_state == ST_DELAY) r_dly <= r_dly - 4'd1;
        if (w_rd)                r_addr <= r_addr + 1'b1;
        if (w_pop)               r_out_idx <= r_out_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= '0;
    end else if (w_flush) begin
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= mem_rd_data;
        r_wptr         <= ~r_wptr;
      end
      if (w_fifo_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_fifo_pop};
    end
  end

endmodule
